// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : pipe_hazard_ctrl_if
// Brief  : ID-stage bus between the pipeline and the hazard/stall controller.
// Rev    : 1.0  initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int NRP  = 2,
    parameter int NFWD = 3,
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int SW   = 6,
    parameter int CW   = 16
);
    logic [NRP*AW-1:0]  rf_raddr;
    logic [NRP-1:0]     rf_ren;
    logic [NRP*DW-1:0]  rf_rdata;
    logic [NFWD-1:0]    fwd_we;
    logic [NFWD*AW-1:0] fwd_waddr;
    logic [NFWD*DW-1:0] fwd_wdata;
    logic [NFWD-1:0]    fwd_pending;
    logic               busy_req;
    logic               flush;
    logic [DW-1:0]      inst_rdata;
    logic [NRP*DW-1:0]  opnd;
    logic [DW-1:0]      inst_out;
    logic [SW-1:0]      stall;
    logic [CW-1:0]      cnt_loaduse;
    logic [CW-1:0]      cnt_busy;

    modport master (
        output rf_raddr, rf_ren, rf_rdata, fwd_we, fwd_waddr, fwd_wdata,
               fwd_pending, busy_req, flush, inst_rdata,
        input  opnd, inst_out, stall, cnt_loaduse, cnt_busy
    );

    modport slave (
        input  rf_raddr, rf_ren, rf_rdata, fwd_we, fwd_waddr, fwd_wdata,
               fwd_pending, busy_req, flush, inst_rdata,
        output opnd, inst_out, stall, cnt_loaduse, cnt_busy
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipe_hazard_ctrl
// Brief  : Operand bypass, load-use/busy stall generation, IF/ID instruction
//          hold and saturating stall counters for the 5-stage core.
// Rev    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int NRP  = 2,
    parameter int NFWD = 3,
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int SW   = 6,
    parameter int CW   = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam logic [SW-1:0] c_stall_busy = SW'(4'b1111);
    localparam logic [SW-1:0] c_stall_lu   = SW'(3'b111);

    logic [NRP-1:0] w_lu_port;
    logic           w_lu_hit;
    logic [SW-1:0]  w_stall;
    logic           r_held_vld;
    logic [DW-1:0]  r_held_inst;
    logic [CW-1:0]  r_cnt_loaduse;
    logic [CW-1:0]  r_cnt_busy;

    generate
        for (genvar p = 0; p < NRP; p++) begin : g_port
            logic [AW-1:0] w_raddr;
            logic          w_hit;
            logic          w_pend;
            logic [DW-1:0] w_fwd;

            assign w_raddr = bus.rf_raddr[p*AW +: AW];

            // Scan oldest to youngest so the youngest matching source wins.
            always_comb begin
                w_hit  = 1'b0;
                w_pend = 1'b0;
                w_fwd  = '0;
                for (int s = NFWD - 1; s >= 0; s--) begin
                    if (bus.fwd_we[s] && (bus.fwd_waddr[s*AW +: AW] == w_raddr) &&
                        (w_raddr != '0)) begin
                        w_hit  = 1'b1;
                        w_pend = bus.fwd_pending[s];
                        w_fwd  = bus.fwd_wdata[s*DW +: DW];
                    end
                end
            end

            assign bus.opnd[p*DW +: DW] = (w_raddr == '0) ? '0 :
                                          w_hit ? w_fwd : bus.rf_rdata[p*DW +: DW];
            assign w_lu_port[p] = bus.rf_ren[p] && w_hit && w_pend;
        end
    endgenerate

    assign w_lu_hit = |w_lu_port;

    always_comb begin
        w_stall = '0;
        if (rst) begin
            w_stall = '0;
        end else if (bus.busy_req) begin
            w_stall = c_stall_busy;
        end else if (w_lu_hit) begin
            w_stall = c_stall_lu;
        end
    end

    assign bus.stall = w_stall;

    // Capture only the first word of a stall run; flush always drops the hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_held_vld  <= 1'b0;
            r_held_inst <= '0;
        end else if (bus.flush) begin
            r_held_vld  <= 1'b0;
        end else if (w_stall[1] && !r_held_vld) begin
            r_held_vld  <= 1'b1;
            r_held_inst <= bus.inst_rdata;
        end else if (!w_stall[1]) begin
            r_held_vld  <= 1'b0;
        end
    end

    assign bus.inst_out = (r_held_vld && !rst) ? r_held_inst : bus.inst_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_loaduse <= '0;
            r_cnt_busy    <= '0;
        end else begin
            if (w_lu_hit && !bus.busy_req && (r_cnt_loaduse != '1)) begin
                r_cnt_loaduse <= r_cnt_loaduse + 1'b1;
            end
            if (bus.busy_req && (r_cnt_busy != '1)) begin
                r_cnt_busy <= r_cnt_busy + 1'b1;
            end
        end
    end

    assign bus.cnt_loaduse = r_cnt_loaduse;
    assign bus.cnt_busy    = r_cnt_busy;
endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_hazard_ctrl
// Brief  : Directed self-checking bench for pipe_hazard_ctrl (CW=16 and CW=4).
// Rev    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    pipe_hazard_ctrl_if #(.CW(16)) hif ();
    pipe_hazard_ctrl_if #(.CW(4))  hif4 ();

    pipe_hazard_ctrl #(.CW(16)) dut   (.clk(clk), .rst(rst), .bus(hif.slave));
    pipe_hazard_ctrl #(.CW(4))  dut_s (.clk(clk), .rst(rst), .bus(hif4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        hif.rf_raddr = '0;   hif.rf_ren = '0;      hif.rf_rdata = '0;
        hif.fwd_we = '0;     hif.fwd_waddr = '0;   hif.fwd_wdata = '0;
        hif.fwd_pending = '0; hif.busy_req = 1'b0; hif.flush = 1'b0;
        hif.inst_rdata = '0;
        hif4.rf_raddr = '0;  hif4.rf_ren = '0;     hif4.rf_rdata = '0;
        hif4.fwd_we = '0;    hif4.fwd_waddr = '0;  hif4.fwd_wdata = '0;
        hif4.fwd_pending = '0; hif4.busy_req = 1'b0; hif4.flush = 1'b0;
        hif4.inst_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk); idle(); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle();
        rst = 1'b1; hif.busy_req = 1'b1; hif.inst_rdata = 32'h55;
        #1;
        total++; if (hif.stall !== 6'b0) begin bad++; $display("FAIL rst_stall: got %b want 000000", hif.stall); end
        total++; if (hif.inst_out !== 32'h55) begin bad++; $display("FAIL rst_inst: got %h want 00000055", hif.inst_out); end
        @(negedge clk);
        rst = 1'b0; hif.busy_req = 1'b0;
        #1;
        total++; if (hif.cnt_busy !== 16'd0 || hif.cnt_loaduse !== 16'd0) begin
            bad++; $display("FAIL rst_cnt: got busy=%0d lu=%0d want 0 0", hif.cnt_busy, hif.cnt_loaduse); end
    endtask

    task automatic test_forward();
        @(negedge clk);
        idle();
        hif.fwd_we = 3'b111;
        hif.fwd_waddr = {5'd5, 5'd5, 5'd5};
        hif.fwd_wdata = {32'h33, 32'h22, 32'h11};
        hif.rf_rdata = {32'h77, 32'h99};
        hif.rf_ren = 2'b01;
        hif.rf_raddr = {5'd3, 5'd5};
        #1;
        total++; if (hif.opnd[31:0] !== 32'h11) begin bad++; $display("FAIL fwd_ex: got %h want 00000011", hif.opnd[31:0]); end
        total++; if (hif.opnd[63:32] !== 32'h77) begin bad++; $display("FAIL fwd_nomatch_p1: got %h want 00000077", hif.opnd[63:32]); end
        hif.fwd_we = 3'b110;
        #1;
        total++; if (hif.opnd[31:0] !== 32'h22) begin bad++; $display("FAIL fwd_mem: got %h want 00000022", hif.opnd[31:0]); end
        hif.fwd_we = 3'b100;
        #1;
        total++; if (hif.opnd[31:0] !== 32'h33) begin bad++; $display("FAIL fwd_wb: got %h want 00000033", hif.opnd[31:0]); end
        hif.fwd_we = 3'b000;
        #1;
        total++; if (hif.opnd[31:0] !== 32'h99) begin bad++; $display("FAIL fwd_rf: got %h want 00000099", hif.opnd[31:0]); end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        idle();
        hif.fwd_we = 3'b001; hif.fwd_waddr = '0; hif.fwd_wdata = {3{32'hFFFF_FFFF}};
        hif.fwd_pending = 3'b001; hif.rf_ren = 2'b11;
        hif.rf_rdata = {32'h1234, 32'h1234};
        #1;
        total++; if (hif.opnd !== 64'd0) begin bad++; $display("FAIL zero_opnd: got %h want 0", hif.opnd); end
        total++; if (hif.stall !== 6'b0) begin bad++; $display("FAIL zero_stall: got %b want 000000", hif.stall); end
    endtask

    task automatic test_loaduse();
        do_reset();
        @(negedge clk);
        idle();
        hif.fwd_we = 3'b001; hif.fwd_waddr = {10'd0, 5'd8}; hif.fwd_pending = 3'b001;
        hif.fwd_wdata = {64'd0, 32'hABCD};
        hif.rf_raddr = {5'd8, 5'd0}; hif.rf_ren = 2'b10;
        #1;
        total++; if (hif.stall !== 6'b000111) begin bad++; $display("FAIL lu_stall: got %b want 000111", hif.stall); end
        total++; if (hif.opnd[63:32] !== 32'hABCD) begin bad++; $display("FAIL lu_opnd: got %h want 0000abcd", hif.opnd[63:32]); end
        @(negedge clk);
        idle();
        #1;
        total++; if (hif.stall !== 6'b0) begin bad++; $display("FAIL lu_drop: got %b want 000000", hif.stall); end
        total++; if (hif.cnt_loaduse !== 16'd1) begin bad++; $display("FAIL lu_cnt: got %0d want 1", hif.cnt_loaduse); end
        hif.fwd_we = 3'b001; hif.fwd_waddr = {10'd0, 5'd8}; hif.fwd_pending = 3'b001;
        hif.rf_raddr = {5'd8, 5'd0}; hif.rf_ren = 2'b00;
        #1;
        total++; if (hif.stall !== 6'b0) begin bad++; $display("FAIL lu_unused: got %b want 000000", hif.stall); end
        @(negedge clk);
        idle();
        #1;
        total++; if (hif.cnt_loaduse !== 16'd1) begin bad++; $display("FAIL lu_cnt_hold: got %0d want 1", hif.cnt_loaduse); end
    endtask

    task automatic test_shadow_busy();
        do_reset();
        @(negedge clk);
        idle();
        hif.fwd_we = 3'b011; hif.fwd_waddr = {5'd0, 5'd8, 5'd8}; hif.fwd_pending = 3'b010;
        hif.fwd_wdata = {32'h0, 32'h2222, 32'h1111};
        hif.rf_raddr = {5'd0, 5'd8}; hif.rf_ren = 2'b01;
        #1;
        total++; if (hif.stall !== 6'b0) begin bad++; $display("FAIL shadow_stall: got %b want 000000", hif.stall); end
        total++; if (hif.opnd[31:0] !== 32'h1111) begin bad++; $display("FAIL shadow_opnd: got %h want 00001111", hif.opnd[31:0]); end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle();
            hif.busy_req = 1'b1;
            if (i == 1 || i == 2) begin
                hif.fwd_we = 3'b001; hif.fwd_waddr = {10'd0, 5'd8}; hif.fwd_pending = 3'b001;
                hif.rf_raddr = {5'd0, 5'd8}; hif.rf_ren = 2'b01;
            end
            #1;
            total++; if (hif.stall !== 6'b001111) begin bad++; $display("FAIL busy_stall[%0d]: got %b want 001111", i, hif.stall); end
        end
        @(negedge clk);
        idle();
        #1;
        total++; if (hif.cnt_busy !== 16'd4) begin bad++; $display("FAIL busy_cnt: got %0d want 4", hif.cnt_busy); end
        total++; if (hif.cnt_loaduse !== 16'd0) begin bad++; $display("FAIL busy_lu_cnt: got %0d want 0", hif.cnt_loaduse); end
    endtask

    task automatic test_hold();
        do_reset();
        @(negedge clk); idle(); hif.busy_req = 1'b1; hif.inst_rdata = 32'hA;
        #1;
        total++; if (hif.inst_out !== 32'hA) begin bad++; $display("FAIL hold_first: got %h want 0000000a", hif.inst_out); end
        @(negedge clk); hif.inst_rdata = 32'hB;
        #1;
        total++; if (hif.inst_out !== 32'hA) begin bad++; $display("FAIL hold_b: got %h want 0000000a", hif.inst_out); end
        @(negedge clk); hif.inst_rdata = 32'hC;
        #1;
        total++; if (hif.inst_out !== 32'hA) begin bad++; $display("FAIL hold_c: got %h want 0000000a", hif.inst_out); end
        @(negedge clk); hif.busy_req = 1'b0; hif.inst_rdata = 32'hD;
        #1;
        total++; if (hif.inst_out !== 32'hA) begin bad++; $display("FAIL hold_release: got %h want 0000000a", hif.inst_out); end
        @(negedge clk); hif.inst_rdata = 32'hE;
        #1;
        total++; if (hif.inst_out !== 32'hE) begin bad++; $display("FAIL hold_live: got %h want 0000000e", hif.inst_out); end
        // Flush in the middle of a stall run
        do_reset();
        @(negedge clk); idle(); hif.busy_req = 1'b1; hif.inst_rdata = 32'h1;
        @(negedge clk); hif.inst_rdata = 32'h2; hif.flush = 1'b1;
        #1;
        total++; if (hif.inst_out !== 32'h1) begin bad++; $display("FAIL flush_pre: got %h want 00000001", hif.inst_out); end
        @(negedge clk); hif.flush = 1'b0; hif.inst_rdata = 32'h3;
        #1;
        total++; if (hif.inst_out !== 32'h3) begin bad++; $display("FAIL flush_live: got %h want 00000003", hif.inst_out); end
        @(negedge clk); hif.inst_rdata = 32'h4;
        #1;
        total++; if (hif.inst_out !== 32'h3) begin bad++; $display("FAIL flush_recap: got %h want 00000003", hif.inst_out); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        @(negedge clk); idle(); hif.busy_req = 1'b1; hif.inst_rdata = 32'h10;
        @(negedge clk); hif.inst_rdata = 32'h11;
        @(negedge clk); rst = 1'b1; hif.inst_rdata = 32'h12;
        #1;
        total++; if (hif.stall !== 6'b0) begin bad++; $display("FAIL rstmid_stall: got %b want 000000", hif.stall); end
        total++; if (hif.inst_out !== 32'h12) begin bad++; $display("FAIL rstmid_inst: got %h want 00000012", hif.inst_out); end
        @(negedge clk); rst = 1'b0; hif.busy_req = 1'b0; hif.inst_rdata = 32'h13;
        #1;
        total++; if (hif.inst_out !== 32'h13) begin bad++; $display("FAIL rstmid_held: got %h want 00000013", hif.inst_out); end
        total++; if (hif.cnt_busy !== 16'd0 || hif.cnt_loaduse !== 16'd0) begin
            bad++; $display("FAIL rstmid_cnt: got busy=%0d lu=%0d want 0 0", hif.cnt_busy, hif.cnt_loaduse); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            hif.busy_req = 1'b1; hif4.busy_req = 1'b1;
        end
        @(negedge clk);
        idle();
        #1;
        total++; if (hif4.cnt_busy !== 4'hF) begin bad++; $display("FAIL sat_cw4: got %0d want 15", hif4.cnt_busy); end
        total++; if (hif.cnt_busy !== 16'd20) begin bad++; $display("FAIL sat_cw16: got %0d want 20", hif.cnt_busy); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle();
        test_reset();
        test_forward();
        test_zero_reg();
        test_loaduse();
        test_shadow_busy();
        test_hold();
        test_reset_mid_stall();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard/stall controller for the 5-stage core, generalising the fixed EX/MEM/WB bypass and load-use CTRL pairing. It sits beside ID and:
- forwards operands for NRP read ports from NFWD bypass sources;
- generates the pipeline stall vector for load-use and long-latency-unit (mul/div) busy;
- holds the fetched instruction across stalls;
- keeps saturating stall-cycle counters.

Parameters:
NRP, 2, number of ID register read ports
NFWD, 3, number of bypass sources; index 0 = youngest (EX), ascending = older (MEM, WB)
DW, 32, datapath width
AW, 5, register address width
SW, 6, stall vector width (`StallBus)
CW, 16, perf counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rf_raddr  in  NRP*AW  ID read addresses, port p at [p*AW+:AW]
rf_ren  in  NRP  read port p actually used by the ID instruction
rf_rdata  in  NRP*DW  register-file read data
fwd_we  in  NFWD  source s writes a register
fwd_waddr  in  NFWD*AW  source s destination
fwd_wdata  in  NFWD*DW  source s result
fwd_pending  in  NFWD  source s result not yet available (load in EX)
busy_req  in  1  multi-cycle unit in EX not done
flush  in  1  discard IF/ID contents (branch/exception)
inst_rdata  in  DW  inst_sram_rdata
opnd  out  NRP*DW  forwarded operands to ID
inst_out  out  DW  instruction presented to ID decode
stall  out  SW  stall vector
cnt_loaduse  out  CW  load-use stall cycles
cnt_busy  out  CW  busy stall cycles

Behaviour:
Clock and reset:
- One clock (clk); reset (rst) is synchronous and active-high.
- Reset clears held_vld, held_inst, cnt_loaduse and cnt_busy to 0.
- Combinational outputs during reset: stall=0, opnd and inst_out follow their inputs.

Forwarding (combinational):
- For each port p, scan s=0..NFWD-1 for a match: fwd_we[s] && fwd_waddr[s]==rf_raddr[p] && rf_raddr[p]!=0.
- The first (lowest s) match wins; opnd[p]=fwd_wdata[s]. No match → rf_rdata[p].
- rf_raddr[p]==0 → opnd[p]=0 always.

Hazards (combinational):
- lu_hit = some p with rf_ren[p], whose winning source has fwd_pending set.
- A pending source shadowed by a younger non-pending match is NOT a hazard.

Stall encoding (bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved 0):
- busy_req=1 → stall=6'b001111 (freeze PC..EX, bubble into MEM). busy_req has priority over lu_hit.
- else lu_hit → stall=6'b000111 (freeze PC..ID, bubble into EX).
- else stall=0.
- flush does not alter stall.

Instruction hold:
- inst_sram returns data one cycle after the address. Freezing IF/ID must not lose the returned word.
- At a clk edge where stall[1]=1 and held_vld=0: held_inst<=inst_rdata, held_vld<=1.
- Edge where stall[1]=0: held_vld<=0.
- flush at an edge: held_vld<=0, overriding capture.
- inst_out = held_vld ? held_inst : inst_rdata.
- Back-to-back stalls (busy followed by load-use) keep the first captured word.

Counters:
- cnt_loaduse += 1 each edge with lu_hit && !busy_req.
- cnt_busy += 1 each edge with busy_req.
- Both saturate at all-ones and are cleared only by rst.

Latency:
- Forwarding and stall are zero-cycle.
- The hold takes effect the cycle after stall rises.

Test Plan:
1. Forwarding priority: EX, MEM and WB all write r5 (0x11/0x22/0x33), rf_rdata=0x99, rf_ren=2'b01, raddr[0]=5 → opnd[0]=0x11. Drop EX → 0x22. Drop all → 0x99.
2. Register zero: raddr=0, fwd_we[0]=1, waddr=0, wdata=0xFFFF_FFFF, rf_rdata=0x1234 → opnd=0, stall=0.
3. Load-use: EX pending load to r8, raddr[1]=8, rf_ren[1]=1 → stall=6'b000111 for exactly that cycle, cnt_loaduse=1. Same with rf_ren[1]=0 → stall=0.
4. Shadowing and busy priority:
   - MEM pending to r8 while EX non-pending writes r8 → stall=0.
   - busy_req held 4 cycles, with lu_hit in cycles 2–3 → stall=6'b001111 in all 4 cycles, cnt_busy=4, cnt_loaduse=0.
5. Instruction hold:
   - stall rises with inst_rdata=0xA; rdata then changes to 0xB, 0xC → inst_out=0xA until stall drops; first unstalled cycle shows live rdata.
   - flush mid-stall → next cycle inst_out=live rdata.
6. Reset and saturation:
   - rst asserted mid-stall → next cycle held_vld=0 and counters=0.
   - With CW=4, 20 busy cycles → cnt_busy=15.
